ht_reset_seq: RTL and testbench

Reset sequencer for one clock domain. It takes the board-level asynchronous active-low reset and the clock-generator lock indication, and produces the clean, synchronous, active-high `i_reset` that drives the reset-flop stage generating `r_reset1x`/`r_reset2x`. Its job is to guarantee that downstream reset is asserted until the clock is stable and the reset-hold interval has elapsed. It also supports a host-requested soft reset and reports loss-of-lock events.

---
 rtl/ht_reset_seq.sv | 121 ++++++++++++
 tb/tb_ht_reset_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ht_reset_seq.sv
// Reset sequencer: holds the synchronous active-high reset until the clock is locked
// and the hold interval has elapsed. Also handles host soft resets and counts lock losses.
`timescale 1ns/1ps
module ht_reset_seq #(
  parameter int SYNC_STAGES = 3,
  parameter int LOCK_FILTER = 16,
  parameter int HOLD_CYCLES = 64,
  localparam int CNT_MAX = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES,
  localparam int CNT_W = $clog2(CNT_MAX + 1)
) (
  input  logic       clk,
  input  logic       i_reset_n,
  input  logic       i_locked,
  input  logic       i_soft_reset,
  output logic       o_reset,
  output logic [1:0] o_state,
  output logic [7:0] o_lock_loss_cnt
);

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_LOCK_WAIT = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LF_LAST   = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   rst_released;
  logic                   lock_ok;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             loss_inc;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rst_sync  <= '0;
      lock_sync <= '0;
    end else begin
      rst_sync  <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
      lock_sync <= {lock_sync[SYNC_STAGES-1-1:0], i_locked};
    end
  end

  // ASSERT is left on the same edge the release reaches the end of the chain.
  assign rst_released = rst_sync[SYNC_STAGES-2] | rst_sync[SYNC_STAGES-1];
  assign lock_ok      = lock_sync[SYNC_STAGES-1];

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    loss_inc = 1'b0;
    case (state)
      ST_ASSERT: begin
        cnt_d = '0;
        if (rst_released) state_d = ST_LOCK_WAIT;
      end
      ST_LOCK_WAIT: begin
        if (!lock_ok) begin
          cnt_d = '0;
        end else if (cnt == LF_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        // Lock loss outranks soft reset, which outranks hold completion.
        if (!lock_ok) begin
          state_d  = ST_LOCK_WAIT;
          cnt_d    = '0;
          loss_inc = 1'b1;
        end else if (i_soft_reset) begin
          cnt_d = '0;
        end else if (cnt == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_ok) begin
          state_d  = ST_LOCK_WAIT;
          cnt_d    = '0;
          loss_inc = 1'b1;
        end else if (i_soft_reset) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state           <= ST_ASSERT;
      cnt             <= '0;
      o_reset         <= 1'b1;
      o_lock_loss_cnt <= 8'd0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      o_reset <= (state_d != ST_RUN);
      if (loss_inc && (o_lock_loss_cnt != 8'hFF))
        o_lock_loss_cnt <= o_lock_loss_cnt + 8'd1;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_ht_reset_seq.sv
// Bench for ht_reset_seq: directed scenarios with spec-derived edge numbers plus a
// randomized run compared against a phase/countdown reference model.
`timescale 1ns/1ps
module tb_ht_reset_seq;
  localparam int SYNC_STAGES = 2;
  localparam int LOCK_FILTER = 4;
  localparam int HOLD_CYCLES = 8;

  logic       clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_locked = 1'b0;
  logic       i_soft_reset = 1'b0;
  logic       o_reset;
  logic [1:0] o_state;
  logic [7:0] o_lock_loss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ht_reset_seq #(
    .SYNC_STAGES(SYNC_STAGES),
    .LOCK_FILTER(LOCK_FILTER),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk            (clk),
    .i_reset_n      (i_reset_n),
    .i_locked       (i_locked),
    .i_soft_reset   (i_soft_reset),
    .o_reset        (o_reset),
    .o_state        (o_state),
    .o_lock_loss_cnt(o_lock_loss_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phase 0..3, consecutive-lock run length, hold cycles remaining, loss count.
  // The lock seen by the sequencer at an edge is i_locked sampled SYNC_STAGES edges earlier.
  int   m_phase = 0;
  int   m_edges = 0;
  int   m_run = 0;
  int   m_hold_left = 0;
  int   m_loss = 0;
  logic m_reset = 1'b1;
  logic m_ls;
  logic lk_q[$];

  initial begin
    for (int i = 0; i < SYNC_STAGES; i++) lk_q.push_back(1'b0);
    forever begin
      @(posedge clk or negedge i_reset_n);
      if (!i_reset_n) begin
        m_phase = 0; m_edges = 0; m_run = 0; m_hold_left = 0; m_loss = 0; m_reset = 1'b1;
        lk_q.delete();
        for (int i = 0; i < SYNC_STAGES; i++) lk_q.push_back(1'b0);
      end else begin
        m_ls = lk_q.pop_front();
        lk_q.push_back(i_locked);
        case (m_phase)
          0: begin
            m_edges++;
            if (m_edges >= SYNC_STAGES) m_phase = 1;
          end
          1: begin
            if (m_ls) begin
              m_run++;
              if (m_run == LOCK_FILTER) begin m_phase = 2; m_hold_left = HOLD_CYCLES; end
            end else m_run = 0;
          end
          2: begin
            if (!m_ls) begin
              m_phase = 1; m_run = 0;
              if (m_loss < 255) m_loss++;
            end else if (i_soft_reset) m_hold_left = HOLD_CYCLES;
            else begin
              m_hold_left--;
              if (m_hold_left == 0) m_phase = 3;
            end
          end
          default: begin
            if (!m_ls) begin
              m_phase = 1; m_run = 0;
              if (m_loss < 255) m_loss++;
            end else if (i_soft_reset) begin
              m_phase = 2; m_hold_left = HOLD_CYCLES;
            end
          end
        endcase
        m_reset = (m_phase != 3);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; the next rising edge samples the inputs.
  task automatic cyc(input logic lk, input logic sr);
    i_locked     = lk;
    i_soft_reset = sr;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    i_reset_n    = 1'b0;
    i_soft_reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_reset_n = 1'b1;
  endtask

  task automatic go_run();
    i_locked = 1'b1;
    apply_reset();
    repeat (14) cyc(1'b1, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (o_reset !== 1'b1) begin n_errors++; $display("FAIL reset_o_reset got %b want 1", o_reset); end
    n_checks++;
    if (o_state !== 2'd0) begin n_errors++; $display("FAIL reset_state got %0d want 0", o_state); end
    n_checks++;
    if (o_lock_loss_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_loss got %0d want 0", o_lock_loss_cnt); end
  endtask

  task automatic test_power_up();
    logic       exp_rst;
    logic [1:0] exp_st;
    i_locked = 1'b1;
    apply_reset();
    for (int e = 1; e <= 18; e++) begin
      cyc(1'b1, 1'b0);
      exp_rst = (e < 14);
      exp_st  = (e < 2) ? 2'd0 : (e < 6) ? 2'd1 : (e < 14) ? 2'd2 : 2'd3;
      n_checks++;
      if (o_reset !== exp_rst) begin n_errors++; $display("FAIL power_up_reset edge %0d got %b want %b", e, o_reset, exp_rst); end
      n_checks++;
      if (o_state !== exp_st) begin n_errors++; $display("FAIL power_up_state edge %0d got %0d want %0d", e, o_state, exp_st); end
    end
    n_checks++;
    if (o_lock_loss_cnt !== 8'd0) begin n_errors++; $display("FAIL power_up_loss got %0d want 0", o_lock_loss_cnt); end
  endtask

  task automatic test_lock_glitch();
    logic exp_rst;
    i_locked = 1'b1;
    apply_reset();
    for (int e = 1; e <= 22; e++) begin
      cyc((e == 4) ? 1'b0 : 1'b1, 1'b0);
      exp_rst = (e < 18);
      n_checks++;
      if (o_reset !== exp_rst) begin n_errors++; $display("FAIL glitch_reset edge %0d got %b want %b", e, o_reset, exp_rst); end
      if (e >= 2 && e <= 9) begin
        n_checks++;
        if (o_state !== 2'd1) begin n_errors++; $display("FAIL glitch_state edge %0d got %0d want 1", e, o_state); end
      end
    end
    n_checks++;
    if (o_lock_loss_cnt !== 8'd0) begin n_errors++; $display("FAIL glitch_loss got %0d want 0", o_lock_loss_cnt); end
  endtask

  task automatic test_soft_reset();
    int hi;
    go_run();
    hi = 0;
    cyc(1'b1, 1'b1);
    n_checks++;
    if (o_state !== 2'd2) begin n_errors++; $display("FAIL soft_state got %0d want 2", o_state); end
    if (o_reset === 1'b1) hi++;
    while (o_reset === 1'b1 && hi < 40) begin
      cyc(1'b1, 1'b0);
      if (o_reset === 1'b1) hi++;
    end
    n_checks++;
    if (hi != HOLD_CYCLES) begin n_errors++; $display("FAIL soft_single_len got %0d want %0d", hi, HOLD_CYCLES); end
    hi = 0;
    cyc(1'b1, 1'b1);
    if (o_reset === 1'b1) hi++;
    repeat (4) begin
      cyc(1'b1, 1'b0);
      if (o_reset === 1'b1) hi++;
    end
    cyc(1'b1, 1'b1);
    if (o_reset === 1'b1) hi++;
    while (o_reset === 1'b1 && hi < 40) begin
      cyc(1'b1, 1'b0);
      if (o_reset === 1'b1) hi++;
    end
    n_checks++;
    if (hi != 5 + HOLD_CYCLES) begin n_errors++; $display("FAIL soft_double_len got %0d want %0d", hi, 5 + HOLD_CYCLES); end
  endtask

  task automatic test_lock_drop();
    int fall;
    go_run();
    cyc(1'b0, 1'b0);
    n_checks++;
    if (o_reset !== 1'b0) begin n_errors++; $display("FAIL drop_early1 got %b want 0", o_reset); end
    cyc(1'b0, 1'b0);
    n_checks++;
    if (o_reset !== 1'b0) begin n_errors++; $display("FAIL drop_early2 got %b want 0", o_reset); end
    cyc(1'b0, 1'b0);
    n_checks++;
    if (o_reset !== 1'b1) begin n_errors++; $display("FAIL drop_rise got %b want 1", o_reset); end
    n_checks++;
    if (o_state !== 2'd1) begin n_errors++; $display("FAIL drop_state got %0d want 1", o_state); end
    n_checks++;
    if (o_lock_loss_cnt !== 8'd1) begin n_errors++; $display("FAIL drop_loss got %0d want 1", o_lock_loss_cnt); end
    fall = -1;
    for (int n = 3; n <= 30; n++) begin
      cyc(1'b1, 1'b0);
      if (o_reset === 1'b0 && fall < 0) fall = n;
    end
    n_checks++;
    if (fall != 16) begin n_errors++; $display("FAIL relock_fall_edge got %0d want 16", fall); end
  endtask

  task automatic test_async_reset();
    logic exp_rst;
    go_run();
    repeat (3) cyc(1'b0, 1'b0);
    repeat (7) cyc(1'b1, 1'b0);
    n_checks++;
    if (o_state !== 2'd2 || o_lock_loss_cnt !== 8'd1) begin
      n_errors++; $display("FAIL async_pre state %0d loss %0d want state 2 loss 1", o_state, o_lock_loss_cnt);
    end
    #2 i_reset_n = 1'b0;
    #1;
    n_checks++;
    if (o_reset !== 1'b1) begin n_errors++; $display("FAIL async_o_reset got %b want 1", o_reset); end
    n_checks++;
    if (o_state !== 2'd0) begin n_errors++; $display("FAIL async_state got %0d want 0", o_state); end
    n_checks++;
    if (o_lock_loss_cnt !== 8'd0) begin n_errors++; $display("FAIL async_loss got %0d want 0", o_lock_loss_cnt); end
    @(negedge clk);
    i_reset_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      cyc(1'b1, 1'b0);
      exp_rst = (e < 14);
      n_checks++;
      if (o_reset !== exp_rst) begin n_errors++; $display("FAIL async_release edge %0d got %b want %b", e, o_reset, exp_rst); end
    end
  endtask

  task automatic test_priority();
    go_run();
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    n_checks++;
    if (o_state !== 2'd1) begin n_errors++; $display("FAIL prio_state got %0d want 1", o_state); end
    n_checks++;
    if (o_lock_loss_cnt !== 8'd1) begin n_errors++; $display("FAIL prio_loss got %0d want 1", o_lock_loss_cnt); end
  endtask

  task automatic test_saturation();
    i_locked = 1'b1;
    apply_reset();
    for (int p = 0; p < 300; p++) begin
      repeat (5) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      if (p % 50 == 0) begin
        n_checks++;
        if (o_lock_loss_cnt !== 8'(m_loss)) begin n_errors++; $display("FAIL sat_model p %0d got %0d want %0d", p, o_lock_loss_cnt, m_loss); end
      end
    end
    repeat (4) cyc(1'b1, 1'b0);
    n_checks++;
    if (o_lock_loss_cnt !== 8'd255) begin n_errors++; $display("FAIL sat_final got %0d want 255", o_lock_loss_cnt); end
  endtask

  task automatic test_random();
    logic lk, sr;
    i_locked = 1'b1;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      lk = ($urandom_range(0, 15) != 0);
      sr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 i_reset_n = 1'b0;
        #1 i_reset_n = 1'b1;
      end
      cyc(lk, sr);
      n_checks++;
      if (o_state !== 2'(m_phase) || o_reset !== m_reset || o_lock_loss_cnt !== 8'(m_loss)) begin
        n_errors++;
        $display("FAIL random cyc %0d got st %0d rst %b loss %0d want st %0d rst %b loss %0d",
                 c, o_state, o_reset, o_lock_loss_cnt, m_phase, m_reset, m_loss);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_power_up();
    test_lock_glitch();
    test_soft_reset();
    test_lock_drop();
    test_async_reset();
    test_priority();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
